// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU, with a single registered response slot.
// Latency 1 cycle; the response slot holds until the consumer takes it. Round-robin when ALU_ARB_ROUND_ROBIN_EN is defined, otherwise fixed priority.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_in1,
    input  logic [XLEN-1:0] req0_in2,
    input  logic [3:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_in1,
    input  logic [XLEN-1:0] req1_in2,
    input  logic [3:0]      req1_op,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_control,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_out,
    output logic            rsp_zero,
    output logic            rsp_err
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state_q;
    logic            rsp_id_q;
    logic [XLEN-1:0] rsp_out_q;
    logic            rsp_zero_q;
    logic            rsp_err_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic            last_grant_q;
`endif

    logic            open_win;
    logic            pick1;
    logic            gnt0;
    logic            gnt1;
    logic [3:0]      sel_op;
    logic            sel_legal;
    logic [XLEN-1:0] rsp_out_d;
    logic            rsp_zero_d;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0110);
    endfunction

    always_comb begin
        // The slot can take a new result when empty or when it is being drained this cycle.
        open_win = !reset && ((state_q == IDLE) || rsp_ready);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        pick1 = req1_valid && (!req0_valid || !last_grant_q);
`else
        pick1 = req1_valid && !req0_valid;
`endif
        gnt1 = open_win && pick1;
        gnt0 = open_win && req0_valid && !pick1;

        sel_op    = gnt1 ? req1_op : req0_op;
        sel_legal = op_legal(sel_op);

        alu_in1     = '0;
        alu_in2     = '0;
        alu_control = 4'b0000;
        if (gnt0) begin
            alu_in1 = req0_in1;
            alu_in2 = req0_in2;
        end else if (gnt1) begin
            alu_in1 = req1_in1;
            alu_in2 = req1_in2;
        end
        if ((gnt0 || gnt1) && sel_legal) begin
            alu_control = sel_op;
        end

        rsp_out_d  = sel_legal ? alu_out : '0;
        rsp_zero_d = sel_legal ? alu_zero : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rsp_id_q   <= 1'b0;
            rsp_out_q  <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else if (gnt0 || gnt1) begin
            state_q    <= RESP;
            rsp_id_q   <= gnt1;
            rsp_out_q  <= rsp_out_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= !sel_legal;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant_q <= gnt1;
`endif
        end else if ((state_q == RESP) && rsp_ready) begin
            state_q <= IDLE;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_out    = rsp_out_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule
